// File: rtl/error_metric_accum.sv
`default_nettype none
// ============================================================================
//  Module   : error_metric_accum
//  Purpose  : Measurement engine for an approximate 8x8 multiplier. Accepts
//             NUM_SAMPLES (a, b, p_apx) samples per run, compares p_apx with
//             the exact product and accumulates error statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module error_metric_accum #(
    parameter int NUM_SAMPLES = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [15:0] p_apx,
    output logic        busy,
    output logic        done,
    output logic [15:0] err_count,
    output logic [31:0] sum_ed_abs,
    output logic [32:0] sum_ed,
    output logic [15:0] max_ed,
    output logic [15:0] sample_count
);

    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_RUN   = 2'd1;
    localparam logic [1:0]  c_ST_DRAIN = 2'd2;
    localparam logic [1:0]  c_ST_DONE  = 2'd3;
    localparam logic [15:0] c_LAST_SAMPLE = 16'(NUM_SAMPLES - 1);

    logic [1:0]  state_q, state_d;

    // Stage 1: exact product and returned product
    logic        s1_valid_q, s1_valid_d;
    logic [15:0] s1_exact_q, s1_exact_d;
    logic [15:0] s1_papx_q,  s1_papx_d;

    // Stage 2: signed error distance and its magnitude
    logic        s2_valid_q, s2_valid_d;
    logic [16:0] s2_diff_q,  s2_diff_d;
    logic [15:0] s2_abs_q,   s2_abs_d;

    // Result accumulators
    logic [15:0] err_count_q,    err_count_d;
    logic [31:0] sum_ed_abs_q,   sum_ed_abs_d;
    logic [32:0] sum_ed_q,       sum_ed_d;
    logic [15:0] max_ed_q,       max_ed_d;
    logic [15:0] sample_count_q, sample_count_d;

    logic        w_accept;
    logic        w_launch;
    logic [16:0] w_diff;
    logic [16:0] w_neg_diff;

    assign w_accept   = in_valid && (state_q == c_ST_RUN);
    assign w_launch   = start && ((state_q == c_ST_IDLE) || (state_q == c_ST_DONE));
    // Zero-extend both operands so the 17-bit difference is exact two's complement
    assign w_diff     = {1'b0, s1_exact_q} - {1'b0, s1_papx_q};
    assign w_neg_diff = 17'd0 - w_diff;

    // Run control: the last accepted sample moves to DRAIN; DRAIN ends once
    // both pipeline stages are empty, i.e. the edge after the final update.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:  if (start) state_d = c_ST_RUN;
            c_ST_RUN:   if (w_accept && (sample_count_q == c_LAST_SAMPLE)) state_d = c_ST_DRAIN;
            c_ST_DRAIN: if (!s1_valid_q && !s2_valid_q) state_d = c_ST_DONE;
            c_ST_DONE:  if (start) state_d = c_ST_RUN;
            default:    state_d = c_ST_IDLE;
        endcase
    end

    // Pipeline next-state: stage 1 captures accepted samples, stage 2 forms the error
    always_comb begin
        s1_valid_d = w_accept;
        s1_exact_d = s1_exact_q;
        s1_papx_d  = s1_papx_q;
        if (w_accept) begin
            s1_exact_d = 16'(a) * 16'(b);
            s1_papx_d  = p_apx;
        end
        s2_valid_d = s1_valid_q;
        s2_diff_d  = s2_diff_q;
        s2_abs_d   = s2_abs_q;
        if (s1_valid_q) begin
            s2_diff_d = w_diff;
            s2_abs_d  = w_diff[16] ? w_neg_diff[15:0] : w_diff[15:0];
        end
    end

    // Accumulator next-state: cleared on the launching edge, updated only by valid stage-2 data
    always_comb begin
        err_count_d    = err_count_q;
        sum_ed_abs_d   = sum_ed_abs_q;
        sum_ed_d       = sum_ed_q;
        max_ed_d       = max_ed_q;
        sample_count_d = sample_count_q;
        if (w_launch) begin
            err_count_d    = 16'd0;
            sum_ed_abs_d   = 32'd0;
            sum_ed_d       = 33'd0;
            max_ed_d       = 16'd0;
            sample_count_d = 16'd0;
        end else begin
            if (w_accept) begin
                sample_count_d = sample_count_q + 16'd1;
            end
            if (s2_valid_q) begin
                if (s2_diff_q != 17'd0) begin
                    err_count_d = err_count_q + 16'd1;
                end
                sum_ed_abs_d = sum_ed_abs_q + {16'd0, s2_abs_q};
                sum_ed_d     = sum_ed_q + {{16{s2_diff_q[16]}}, s2_diff_q};
                if (s2_abs_q > max_ed_q) begin
                    max_ed_d = s2_abs_q;
                end
            end
        end
    end

    // State registers; reset discards in-flight samples and clears every result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= c_ST_IDLE;
            s1_valid_q     <= 1'b0;
            s1_exact_q     <= 16'd0;
            s1_papx_q      <= 16'd0;
            s2_valid_q     <= 1'b0;
            s2_diff_q      <= 17'd0;
            s2_abs_q       <= 16'd0;
            err_count_q    <= 16'd0;
            sum_ed_abs_q   <= 32'd0;
            sum_ed_q       <= 33'd0;
            max_ed_q       <= 16'd0;
            sample_count_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            s1_valid_q     <= s1_valid_d;
            s1_exact_q     <= s1_exact_d;
            s1_papx_q      <= s1_papx_d;
            s2_valid_q     <= s2_valid_d;
            s2_diff_q      <= s2_diff_d;
            s2_abs_q       <= s2_abs_d;
            err_count_q    <= err_count_d;
            sum_ed_abs_q   <= sum_ed_abs_d;
            sum_ed_q       <= sum_ed_d;
            max_ed_q       <= max_ed_d;
            sample_count_q <= sample_count_d;
        end
    end

    assign in_ready     = (state_q == c_ST_RUN);
    assign busy         = (state_q == c_ST_RUN) || (state_q == c_ST_DRAIN);
    assign done         = (state_q == c_ST_DONE);
    assign err_count    = err_count_q;
    assign sum_ed_abs   = sum_ed_abs_q;
    assign sum_ed       = sum_ed_q;
    assign max_ed       = max_ed_q;
    assign sample_count = sample_count_q;

endmodule
`default_nettype wire

// File: tb/tb_error_metric_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_error_metric_accum
//  Purpose  : Self-checking bench for error_metric_accum. Three instances with
//             NUM_SAMPLES = 4, 1 and 2 are exercised one at a time against a
//             cycle-level reference model of the run rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_error_metric_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start     [3];
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [7:0]  a         [3];
    logic [7:0]  b         [3];
    logic [15:0] p_apx     [3];
    logic        busy      [3];
    logic        done      [3];
    logic [15:0] err_count [3];
    logic [31:0] sum_ed_abs[3];
    logic [32:0] sum_ed    [3];
    logic [15:0] max_ed    [3];
    logic [15:0] sample_count[3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int NS = (gi == 0) ? 4 : ((gi == 1) ? 1 : 2);
            error_metric_accum #(.NUM_SAMPLES(NS)) u_dut (
                .clk         (clk),
                .rst         (rst),
                .start       (start[gi]),
                .in_valid    (in_valid[gi]),
                .in_ready    (in_ready[gi]),
                .a           (a[gi]),
                .b           (b[gi]),
                .p_apx       (p_apx[gi]),
                .busy        (busy[gi]),
                .done        (done[gi]),
                .err_count   (err_count[gi]),
                .sum_ed_abs  (sum_ed_abs[gi]),
                .sum_ed      (sum_ed[gi]),
                .max_ed      (max_ed[gi]),
                .sample_count(sample_count[gi])
            );
        end
    endgenerate

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic signed [63:0] obs, input longint exp);
        checks++;
        if (obs !== 64'(exp)) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int eff;   // edge number on which the result must appear
        int d;     // exact - approximate
    } pend_t;

    typedef struct {
        bit         v;
        logic [7:0] a;
        logic [7:0] b;
        logic [15:0] p;
    } smp_t;

    pend_t  pend[$];
    smp_t   lst[$];
    int     edge_n   = 0;
    int     acc      = 0;    // samples accepted in this run
    int     since    = 0;    // edges since the final accept
    bit     m_active = 1'b0; // a run has been launched since reset
    longint m_err, m_abs, m_sum, m_max;

    function automatic int n_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 2);
    endfunction

    function automatic bit exp_done(input int k);
        return m_active && (acc == n_of(k)) && (since >= 3);
    endfunction

    function automatic bit exp_ready(input int k);
        return m_active && (acc < n_of(k));
    endfunction

    task automatic clear_model();
        m_err = 0; m_abs = 0; m_sum = 0; m_max = 0;
        acc = 0; since = 0;
        pend.delete();
    endtask

    task automatic check_outputs(input int k);
        check("in_ready",     in_ready[k],     exp_ready(k));
        check("busy",         busy[k],         m_active && !exp_done(k));
        check("done",         done[k],         exp_done(k));
        check("sample_count", sample_count[k], acc);
        check("err_count",    err_count[k],    m_err);
        check("sum_ed_abs",   sum_ed_abs[k],   m_abs);
        check("sum_ed",       $signed(sum_ed[k]), m_sum);
        check("max_ed",       max_ed[k],       m_max);
    endtask

    // One clock cycle: drive at negedge, model the rising edge, check at next negedge
    task automatic step(input int k, input bit st, input bit v,
                        input logic [7:0] av, input logic [7:0] bv, input logic [15:0] pv);
        bit    pre_done;
        bit    pre_rdy;
        pend_t e;
        int    dd;
        start[k] = st; in_valid[k] = v; a[k] = av; b[k] = bv; p_apx[k] = pv;
        pre_done = exp_done(k);
        pre_rdy  = exp_ready(k);
        @(posedge clk);
        edge_n++;
        while (pend.size() > 0 && pend[0].eff == edge_n) begin
            e  = pend.pop_front();
            dd = (e.d < 0) ? -e.d : e.d;
            if (e.d != 0) m_err++;
            m_abs += dd;
            m_sum += e.d;
            if (dd > m_max) m_max = dd;
        end
        if (pre_rdy && v) begin
            acc++;
            e.eff = edge_n + 2;
            e.d   = int'(av) * int'(bv) - int'(pv);
            pend.push_back(e);
            if (acc == n_of(k)) since = 0;
        end else if (m_active && acc == n_of(k) && since < 1000) begin
            since++;
        end
        if (st && (!m_active || pre_done)) begin
            clear_model();
            m_active = 1'b1;
        end
        @(negedge clk);
        start[k] = 1'b0; in_valid[k] = 1'b0;
        check_outputs(k);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; in_valid[i] = 1'b0; a[i] = 8'd0; b[i] = 8'd0; p_apx[i] = 16'd0;
        end
        @(posedge clk);
        edge_n++;
        clear_model();
        m_active = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) check_outputs(i);
    endtask

    task automatic add(input bit v, input int av, input int bv, input int pv);
        smp_t s;
        s.v = v; s.a = 8'(av); s.b = 8'(bv); s.p = 16'(pv);
        lst.push_back(s);
    endtask

    task automatic rand_sample(output logic [7:0] av, output logic [7:0] bv, output logic [15:0] pv);
        int ex;
        int p;
        av = 8'($urandom_range(0, 255));
        bv = 8'($urandom_range(0, 255));
        ex = int'(av) * int'(bv);
        case ($urandom_range(0, 3))
            0:       p = ex;
            1:       p = ex + int'($urandom_range(0, 300)) - 150;
            2:       p = int'($urandom_range(0, 65535));
            default: p = (($urandom_range(0, 1)) != 0) ? 0 : 65535;
        endcase
        if (p < 0) p = 0;
        if (p > 65535) p = 65535;
        pv = 16'(p);
    endtask

    // Junk traffic after the run: must never be accepted
    task automatic drain(input int k);
        logic [7:0]  av, bv;
        logic [15:0] pv;
        for (int i = 0; i < 8; i++) begin
            rand_sample(av, bv, pv);
            step(k, 1'b0, 1'($urandom_range(0, 1)), av, bv, pv);
        end
    endtask

    task automatic run_list(input int k);
        step(k, 1'b1, 1'b0, 8'd0, 8'd0, 16'd0);
        foreach (lst[i]) step(k, 1'b0, lst[i].v, lst[i].a, lst[i].b, lst[i].p);
        drain(k);
        lst.delete();
    endtask

    task automatic rand_run(input int k);
        logic [7:0]  av, bv;
        logic [15:0] pv;
        int guard = 0;
        step(k, 1'b1, 1'b0, 8'd0, 8'd0, 16'd0);
        while (acc < n_of(k) && guard < 200) begin
            rand_sample(av, bv, pv);
            step(k, 1'b0, 1'($urandom_range(0, 1)), av, bv, pv);
            guard++;
        end
        drain(k);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; in_valid[i] = 1'b0; a[i] = 8'd0; b[i] = 8'd0; p_apx[i] = 16'd0;
        end
        @(negedge clk);
        do_reset();

        // Exact products only: no error anywhere
        add(1, 3, 5, 15); add(1, 0, 9, 0); add(1, 255, 255, 65025); add(1, 12, 12, 144);
        run_list(0);

        // Valid toggling: the seventh sample arrives after in_ready drops
        add(1, 1, 2, 3); add(0, 9, 9, 9); add(1, 200, 100, 19000); add(1, 7, 7, 50);
        add(0, 1, 1, 1); add(1, 0, 0, 5); add(1, 250, 250, 0);
        run_list(0);

        // Reset mid-run with start pulsed during RUN
        step(0, 1'b1, 1'b0, 8'd0, 8'd0, 16'd0);
        step(0, 1'b0, 1'b1, 8'd2, 8'd5, 16'd0);
        step(0, 1'b0, 1'b1, 8'd3, 8'd3, 16'd9);
        step(0, 1'b1, 1'b1, 8'd4, 8'd4, 16'd10);
        step(0, 1'b1, 1'b0, 8'd0, 8'd0, 16'd0);
        do_reset();
        add(1, 10, 20, 201); add(1, 30, 30, 900); add(1, 1, 1, 0); add(1, 128, 2, 255);
        run_list(0);

        for (int r = 0; r < 6; r++) rand_run(0);

        do_reset();
        // Maximum single-sample error, then restarts from DONE
        add(1, 255, 255, 0);
        run_list(1);
        for (int r = 0; r < 5; r++) rand_run(1);

        do_reset();
        // Errors of opposite sign cancel in sum_ed but not in sum_ed_abs
        add(1, 10, 10, 90); add(1, 10, 10, 110);
        run_list(2);
        for (int r = 0; r < 5; r++) rand_run(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
